// File: rtl/ex_muldiv_unit_pkg.sv
// Shared cpu definitions for the M-extension execute unit: encodings,
// FSM states and iteration count.
package ex_muldiv_unit_pkg;

  localparam logic [6:0]  MULDIV_FUNCT7 = 7'b0000001;
  localparam int unsigned ITER_COUNT    = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  function automatic logic isDivide(input muldiv_funct3_e f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: operand magnitudes, one shift-add or
// restoring-subtract step per cycle, and a final sign/select/special fix.
module muldiv_datapath
  import ex_muldiv_unit_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           fix_i,
  input  muldiv_funct3_e op_i,
  input  logic [31:0]    rsData_i,
  input  logic [31:0]    rtData_i,
  output logic [31:0]    result_o
);

  muldiv_funct3_e opReg;
  logic [63:0]    acc;       // mul: {product hi, multiplier}; div: {remainder, quotient}
  logic [31:0]    operand;   // multiplicand or divisor magnitude
  logic [31:0]    dividend;
  logic           negA;
  logic           negB;
  logic           divZero;

  logic           signedA;
  logic           signedB;
  logic           aNeg;
  logic           bNeg;
  logic [31:0]    magA;
  logic [31:0]    magB;
  logic [32:0]    mulSum;
  logic [32:0]    remShift;
  logic [32:0]    divTrial;
  logic [63:0]    prodSigned;
  logic [31:0]    fixResult;

  always_comb begin
    signedA  = op_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    signedB  = op_i inside {F3_MULH, F3_DIV, F3_REM};
    aNeg     = signedA & rsData_i[31];
    bNeg     = signedB & rtData_i[31];
    magA     = aNeg ? -rsData_i : rsData_i;
    magB     = bNeg ? -rtData_i : rtData_i;
    mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    remShift = {acc[63:32], acc[31]};
    divTrial = remShift - {1'b0, operand};
  end

  always_comb begin
    prodSigned = (negA ^ negB) ? -acc : acc;
    fixResult  = '0;
    case (opReg)
      F3_MUL:              fixResult = acc[31:0];
      F3_MULH, F3_MULHSU:  fixResult = prodSigned[63:32];
      F3_MULHU:            fixResult = acc[63:32];
      F3_DIV:              fixResult = divZero ? '1 : ((negA ^ negB) ? -acc[31:0] : acc[31:0]);
      F3_DIVU:             fixResult = divZero ? '1 : acc[31:0];
      F3_REM:              fixResult = divZero ? dividend : (negA ? -acc[63:32] : acc[63:32]);
      F3_REMU:             fixResult = divZero ? dividend : acc[63:32];
      default:             fixResult = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opReg    <= F3_MUL;
      acc      <= '0;
      operand  <= '0;
      dividend <= '0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      divZero  <= 1'b0;
      result_o <= '0;
    end else begin
      if (load_i) begin
        opReg    <= op_i;
        dividend <= rsData_i;
        negA     <= aNeg;
        negB     <= bNeg;
        divZero  <= (rtData_i == '0);
        if (isDivide(op_i)) begin
          acc     <= {32'd0, magA};
          operand <= magB;
        end else begin
          acc     <= {32'd0, magB};
          operand <= magA;
        end
      end else if (step_i) begin
        if (isDivide(opReg)) begin
          if (!divTrial[32]) acc <= {divTrial[31:0], acc[30:0], 1'b1};
          else               acc <= {remShift[31:0], acc[30:0], 1'b0};
        end else begin
          acc <= {mulSum, acc[31:1]};
        end
      end
      if (fix_i) result_o <= fixResult;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage M-extension unit: control FSM and pipeline stall/done handshake
// around the iterative multiply/divide datapath.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] rsData_i,
  input  logic [31:0] rtData_i,
  input  logic [4:0]  wbAddr_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  wbAddr_o
);

  muldiv_state_e state;
  muldiv_state_e stateNext;
  logic [4:0]    iterCnt;
  logic [4:0]    wbLatch;
  logic          load;
  logic          step;
  logic          fix;
  logic          unusedFunct7;

  // funct7 was already decoded upstream into start_i
  assign unusedFunct7 = ^funct_i[9:3];

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      ST_IDLE: if (start_i) begin
        load      = 1'b1;
        stateNext = ST_CALC;
      end
      ST_CALC: begin
        step = 1'b1;
        if (iterCnt == 5'(ITER_COUNT - 1)) stateNext = ST_FIX;
      end
      ST_FIX: begin
        fix       = 1'b1;
        stateNext = ST_DONE;
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      iterCnt  <= '0;
      wbLatch  <= '0;
      wbAddr_o <= '0;
    end else begin
      state <= stateNext;
      if (load) begin
        iterCnt <= '0;
        wbLatch <= wbAddr_i;
      end else if (step) begin
        iterCnt <= iterCnt + 5'd1;
      end
      if (fix) wbAddr_o <= wbLatch;
    end
  end

  assign stall_o = !rst_i && ((state == ST_IDLE && start_i) ||
                              state == ST_CALC || state == ST_FIX);
  assign done_o  = (state == ST_DONE);

  muldiv_datapath u_datapath (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .step_i   (step),
    .fix_i    (fix),
    .op_i     (muldiv_funct3_e'(funct_i[2:0])),
    .rsData_i (rsData_i),
    .rtData_i (rtData_i),
    .result_o (result_o)
  );

endmodule
